// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: per-channel edge/pulse detectors feed pending flags, and a
// round-robin scheduler serialises them onto a single valid/ready event port.
// Optional build macro PULSE_EVT_TIMESTAMP_EN adds a free-running timestamp
// counter, a per-channel capture register and the evt_ts output.

// Per-channel detector plus pending/overflow bookkeeping.
module pea_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic mode_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic grant_i,
  output logic pend_o,
  output logic ovf_o,
  output logic cap_o
);
  logic h0_q, h1_q;
  logic pend_q, pend_d;
  logic ovf_q, ovf_d;
  logic det;

  // mode 0: rising edge; mode 1: isolated one-cycle high pulse (010)
  assign det = en_i & (mode_i ? (~h1_q & h0_q & ~a_i) : (~h0_q & a_i));

  // Timestamp capture: a fresh event enters an empty slot, or replaces the one
  // being granted this cycle. An overflowing event keeps the oldest stamp.
  assign cap_o = det & ~clr_i & (~pend_q | grant_i);

  // Pending/overflow next state; clear beats a same-cycle detection
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (det) begin
      pend_d = 1'b1;
      if (grant_i)     ovf_d = 1'b0;
      else if (pend_q) ovf_d = 1'b1;
    end else if (grant_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  // History shift runs regardless of en; pending/overflow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h0_q   <= 1'b0;
      h1_q   <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      h1_q   <= h0_q;
      h0_q   <= a_i;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
endmodule

module pulse_event_arbiter #(
  parameter  int N    = 4,
  parameter  int TS_W = 16,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    mode,
  input  logic            en,
  input  logic            clr,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_overflow
`ifdef PULSE_EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0] evt_ts
`endif
);
  logic [N-1:0]    pend, ovf, cap, grant_vec;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            load;
  logic            evt_valid_q, evt_valid_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic            evt_ovf_q, evt_ovf_d;

  // The output slot may take a new event when empty or being consumed
  assign load = ~evt_valid_q | evt_ready;

  pea_chan u_chan [N-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (a),
    .mode_i  (mode),
    .en_i    (en),
    .clr_i   (clr),
    .grant_i (grant_vec),
    .pend_o  (pend),
    .ovf_o   (ovf),
    .cap_o   (cap)
  );

  // Round-robin search: first pending channel at ptr, ptr+1, ... wrapping at N
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && pend[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  // One-hot grant back to the channels, only when the slot actually loads
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < N; i++)
      grant_vec[i] = load & gnt_any & (gnt_id == ID_W'(i));
  end

  // Output slot and pointer next state; everything holds under backpressure
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_ovf_d   = evt_ovf_q;
    ptr_d       = ptr_q;
    if (load) begin
      evt_valid_d = gnt_any;
      if (gnt_any) begin
        evt_id_d  = gnt_id;
        evt_ovf_d = ovf[gnt_id];
        ptr_d     = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // Output slot and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_ovf_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_ovf_q   <= evt_ovf_d;
      ptr_q       <= ptr_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_id       = evt_id_q;
  assign evt_overflow = evt_ovf_q;

`ifdef PULSE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0]        ts_cnt_q;
  logic [N-1:0][TS_W-1:0] ts_q;
  logic [TS_W-1:0]        evt_ts_q;

  // Free-running stamp counter, per-channel capture, stamp travels with the grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
      evt_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      for (int i = 0; i < N; i++)
        if (cap[i]) ts_q[i] <= ts_cnt_q;
      if (load && gnt_any) evt_ts_q <= ts_q[gnt_id];
    end
  end

  assign evt_ts = evt_ts_q;
`else
  logic unused_cap;
  assign unused_cap = ^cap;
`endif
endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Self-checking bench for pulse_event_arbiter: directed scenarios followed by a
// randomized run, all compared each cycle against a rule-level reference model.
module tb_pulse_event_arbiter;
  localparam int N = 4;
`ifdef PULSE_EVT_TIMESTAMP_EN
  localparam int TS_W = 4;
`else
  localparam int TS_W = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, clr, evt_ready;
  logic [N-1:0] a, mode;
  logic         evt_valid, evt_overflow;
  logic [1:0]   evt_id;
`ifdef PULSE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  bit [N-1:0] m_h0, m_h1, m_pend, m_ovf;
  int m_ptr, m_id, m_ets, m_tscnt;
  bit m_valid, m_eovf;
  int m_ts [N];

  always #5 clk = ~clk;

  pulse_event_arbiter #(.N(N), .TS_W(TS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .mode         (mode),
    .en           (en),
    .clr          (clr),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_overflow (evt_overflow)
`ifdef PULSE_EVT_TIMESTAMP_EN
    ,
    .evt_ts       (evt_ts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: model applies the rules to the inputs of this cycle,
  // then the DUT outputs of the next cycle are compared against it.
  task automatic tick();
    bit [N-1:0] det;
    bit gv, load, gr;
    int g, c;
    det = '0; gv = 1'b0; g = 0;
    if (!rst_n) begin
      m_h0 = '0; m_h1 = '0; m_pend = '0; m_ovf = '0;
      m_ptr = 0; m_valid = 1'b0; m_id = 0; m_eovf = 1'b0;
      m_tscnt = 0; m_ets = 0;
      for (int i = 0; i < N; i++) m_ts[i] = 0;
    end else begin
      for (int i = 0; i < N; i++)
        det[i] = en && (mode[i] ? (!m_h1[i] && m_h0[i] && !a[i]) : (!m_h0[i] && a[i]));
      load = !m_valid || evt_ready;
      if (load)
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!gv && m_pend[c]) begin gv = 1'b1; g = c; end
        end
      if (load) begin
        m_valid = gv;
        if (gv) begin
          m_id = g; m_eovf = m_ovf[g]; m_ets = m_ts[g]; m_ptr = (g + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        gr = gv && (g == i);
        if (clr) begin
          m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
        end else if (det[i]) begin
          if (!m_pend[i] || gr) m_ts[i] = m_tscnt;
          if (gr) m_ovf[i] = 1'b0;
          else if (m_pend[i]) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (gr) begin
          m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
        end
      end
      m_h1 = m_h0;
      m_h0 = a;
      m_tscnt = (m_tscnt + 1) % (1 << TS_W);
    end
    @(posedge clk);
    #1;
    chk("model_valid", evt_valid, m_valid);
    if (m_valid) begin
      chk("model_id", evt_id, m_id);
      chk("model_ovf", evt_overflow, m_eovf);
`ifdef PULSE_EVT_TIMESTAMP_EN
      chk("model_ts", evt_ts, m_ets);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; a = 4'hF; mode = 4'h0; en = 1'b1; clr = 1'b0; evt_ready = 1'b1;

    // 1: reset state, then a=F held from cycle 0 -> ids 0..3 in cycles 2..5
    tick(); tick();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_ovf", evt_overflow, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c + 1 >= 2 && c + 1 <= 5) begin
        chk("t1_valid", evt_valid, 1);
        chk("t1_id", evt_id, c - 1);
      end else chk("t1_idle", evt_valid, 0);
    end

    // 2: pulse detector on ch0, 010 yields one event, 0110 yields none
    mode = 4'b0001; a = 4'hE;
    tick(); tick();
    a = 4'hF; tick();
    a = 4'hE; tick();
    chk("t2_lat1", evt_valid, 0);
    tick();
    chk("t2_valid", evt_valid, 1);
    chk("t2_id", evt_id, 0);
    chk("t2_ovf", evt_overflow, 0);
    tick();
    chk("t2_once", evt_valid, 0);
    a = 4'hF; tick(); tick();
    a = 4'hE;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t2_wide", evt_valid, 0);
    end

    // 3: move ptr to 2, then all four rise together -> 2,3,0,1
    mode = 4'h0; a = 4'h0; tick(); tick();
    a = 4'b0010; tick();
    a = 4'h0; tick(); tick();
    chk("t3_pre_id", evt_id, 1);
    tick();
    a = 4'hF; tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t3_valid", evt_valid, 1);
      chk("t3_id", evt_id, (2 + j) % 4);
    end
    tick();
    chk("t3_end", evt_valid, 0);

    // 4: backpressure holds ch0 while ch1 overflows
    a = 4'h0; tick();
    evt_ready = 1'b0;
    a = 4'b0001; tick(); tick(); tick();
    chk("t4_valid", evt_valid, 1);
    chk("t4_id", evt_id, 0);
    for (int j = 0; j < 6; j++) begin
      a = (j % 2 == 0) ? 4'b0011 : 4'b0001;
      tick();
      chk("t4_hold_id", evt_id, 0);
      chk("t4_hold_ovf", evt_overflow, 0);
    end
    evt_ready = 1'b1; tick();
    chk("t4_next_id", evt_id, 1);
    chk("t4_next_ovf", evt_overflow, 1);
    tick();
    chk("t4_end", evt_valid, 0);

    // 5: clr beats a same-cycle detection; reset drops an in-flight event
    a = 4'h0; tick();
    a = 4'b1000; clr = 1'b1; tick();
    clr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t5_clr", evt_valid, 0);
    end
    evt_ready = 1'b0; a = 4'h0; tick();
    a = 4'b0100; tick();
    a = 4'h0; tick(); tick();
    chk("t5_inflight", evt_valid, 1);
    rst_n = 1'b0; tick();
    chk("t5_rst", evt_valid, 0);
    rst_n = 1'b1; evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t5_empty", evt_valid, 0);
    end

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) < 3) a[i] = ~a[i];
      if ($urandom_range(0, 19) == 0) mode = N'($urandom);
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      evt_ready = ($urandom_range(0, 9) < 6);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end

`ifdef PULSE_EVT_TIMESTAMP_EN
    // 6: stamps at ts_cnt=E and, after the wrap, at ts_cnt=1
    rst_n = 1'b0; a = 4'h0; mode = 4'h0; en = 1'b1; clr = 1'b0; evt_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    a = 4'b0100; tick(); tick();
    chk("t6_id", evt_id, 2);
    chk("t6_ts", evt_ts, 4'hE);
    a = 4'h0; tick();
    a = 4'b0100; tick(); tick();
    chk("t6_wrap_id", evt_id, 2);
    chk("t6_wrap_ts", evt_ts, 4'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
